// File: rtl/pmod_ad1_capture.sv
// Periodic PmodAD1 capture into 4-byte frames; tick to first out_valid is 34*CLK_DIV+2 cycles.
// A frame is held until all 4 bytes are accepted; frames committed while it is held are dropped (sticky overflow).
module pmod_ad1_capture #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1134
) (
    input  logic        clk0,
    input  logic        reset,
    input  logic        enable,
    output logic        adc_ncs,
    output logic        adc_sclk,
    input  logic        adc_sdata1,
    input  logic        adc_sdata2,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] sample1,
    output logic [11:0] sample2,
    output logic        overflow,
    output logic        busy
);

    localparam int TMR_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(SAMPLE_PERIOD - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]       LAST_PHASE = 6'd32;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        QUIET,
        COMMIT
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [TMR_W-1:0] timer_q;
    logic [DIV_W-1:0] div_q;
    logic [5:0]       phase_q;
    logic [11:0]      shift1_q;
    logic [11:0]      shift2_q;
    logic [3:0][7:0]  frame_q;
    logic [1:0]       byte_idx_q;
    logic             tick;
    logic             div_end;
    logic             last_phase;
    logic             commit;
    logic             accept;
    logic             buf_free;

    assign tick       = enable && (timer_q == TMR_LAST);
    assign div_end    = (div_q == DIV_LAST);
    assign last_phase = (phase_q == LAST_PHASE);
    assign accept     = out_valid && out_ready;
    // Draining the last byte frees the buffer in the same cycle a new frame may arrive.
    assign buf_free   = !out_valid || (accept && (byte_idx_q == 2'd3));

    always_ff @(posedge clk0) begin
        if (reset || !enable || tick) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk0) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adc_ncs = 1'b1;
        busy    = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                adc_ncs = 1'b0;
                busy    = 1'b1;
                if (div_end && last_phase) begin
                    state_d = QUIET;
                end
            end
            QUIET: begin
                if (div_end) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Phase 0 is the initial high phase; odd phases are SCLK low, so leaving one is a rising edge.
    // The 4 leading ADC bits simply fall off the top of the 12-bit shifters.
    always_ff @(posedge clk0) begin
        if (reset) begin
            div_q    <= '0;
            phase_q  <= '0;
            adc_sclk <= 1'b1;
            shift1_q <= '0;
            shift2_q <= '0;
        end else begin
            case (state_q)
                CONVERT: begin
                    if (div_end) begin
                        div_q <= '0;
                        if (!last_phase) begin
                            phase_q  <= phase_q + 6'd1;
                            adc_sclk <= ~adc_sclk;
                            if (phase_q[0]) begin
                                shift1_q <= {shift1_q[10:0], adc_sdata1};
                                shift2_q <= {shift2_q[10:0], adc_sdata2};
                            end
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                QUIET: begin
                    div_q <= div_end ? '0 : div_q + DIV_W'(1);
                end
                default: begin
                    div_q    <= '0;
                    phase_q  <= '0;
                    adc_sclk <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk0) begin
        if (reset) begin
            sample1    <= '0;
            sample2    <= '0;
            overflow   <= 1'b0;
            frame_q    <= '0;
            byte_idx_q <= '0;
            out_valid  <= 1'b0;
        end else begin
            if (accept) begin
                byte_idx_q <= byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                    out_valid <= 1'b0;
                end
            end
            if (commit) begin
                sample1 <= shift1_q;
                sample2 <= shift2_q;
                if (buf_free) begin
                    frame_q    <= {shift2_q[11:4], {4'b0000, shift2_q[3:0]},
                                   shift1_q[11:4], {4'b0000, shift1_q[3:0]}};
                    byte_idx_q <= 2'd0;
                    out_valid  <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    assign out_data = frame_q[byte_idx_q];

endmodule

// File: tb/tb_pmod_ad1_capture.sv
// Directed bench for pmod_ad1_capture: AD7476-style ADC model, byte scoreboard, protocol monitor.
module tb_pmod_ad1_capture;

    localparam int CLK_DIV       = 2;
    localparam int SAMPLE_PERIOD = 80;
    localparam int LATENCY       = 34 * CLK_DIV + 1;  // nCS fall to first out_valid

    logic        clk0 = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        adc_ncs;
    logic        adc_sclk;
    logic        adc_sdata1;
    logic        adc_sdata2;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] sample1;
    logic [11:0] sample2;
    logic        overflow;
    logic        busy;

    always #5 clk0 = ~clk0;

    pmod_ad1_capture #(
        .CLK_DIV      (CLK_DIV),
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) dut (
        .clk0      (clk0),
        .reset     (reset),
        .enable    (enable),
        .adc_ncs   (adc_ncs),
        .adc_sclk  (adc_sclk),
        .adc_sdata1(adc_sdata1),
        .adc_sdata2(adc_sdata2),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sample1   (sample1),
        .sample2   (sample2),
        .overflow  (overflow),
        .busy      (busy)
    );

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ADC model: word latched at nCS fall, next bit presented after each SCLK rise.
    logic [15:0] w1 = '0;
    logic [15:0] w2 = '0;
    logic [15:0] lat1 = '0;
    logic [15:0] lat2 = '0;
    int          rises_m = 0;

    always @(negedge adc_ncs) begin
        lat1    = w1;
        lat2    = w2;
        rises_m = 0;
    end

    always @(posedge adc_sclk) begin
        if (adc_ncs === 1'b0) rises_m = rises_m + 1;
    end

    always_comb begin
        adc_sdata1 = 1'b0;
        adc_sdata2 = 1'b0;
        if (adc_ncs === 1'b0 && rises_m < 16) begin
            adc_sdata1 = lat1[4'(15 - rises_m)];
            adc_sdata2 = lat2[4'(15 - rises_m)];
        end
    end

    int         ncs_falls = 0;
    int         fall_cyc = 0;
    int         valid_rise_cyc = 0;
    int         rises_cnt = 0;
    logic       prev_ncs = 1'b1;
    logic       prev_sclk = 1'b1;
    logic       prev_valid = 1'b0;
    logic       aborted = 1'b0;
    logic       pend = 1'b0;
    logic [7:0] pend_dat = '0;

    always @(posedge clk0) cyc <= cyc + 1;

    always @(negedge clk0) begin
        if (reset) begin
            aborted <= 1'b1;
            pend    <= 1'b0;
        end else begin
            if (pend) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(pend_dat));
            end
            if (out_valid && out_ready) begin
                check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("byte", 32'(out_data), 32'(exp_q.pop_front()));
            end
            pend     <= out_valid && !out_ready;
            pend_dat <= out_data;
        end
        if (prev_ncs && !adc_ncs) begin
            ncs_falls <= ncs_falls + 1;
            fall_cyc  <= cyc;
            rises_cnt <= 0;
            aborted   <= 1'b0;
        end
        if (!adc_ncs && !prev_sclk && adc_sclk) rises_cnt <= rises_cnt + 1;
        if (!prev_ncs && adc_ncs && !aborted) check("sclk_rises", 32'(rises_cnt), 32'd16);
        if (!prev_valid && out_valid) valid_rise_cyc <= cyc;
        prev_ncs   <= adc_ncs;
        prev_sclk  <= adc_sclk;
        prev_valid <= out_valid;
    end

    // mode 0: ready low, 1: ready high, 2: ready toggles every cycle
    task automatic step(input int mode);
        @(posedge clk0);
        #1;
        case (mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ~out_ready;
        endcase
    endtask

    task automatic push_frame(input logic [15:0] a, input logic [15:0] b);
        exp_q.push_back({4'b0000, a[3:0]});
        exp_q.push_back(a[11:4]);
        exp_q.push_back({4'b0000, b[3:0]});
        exp_q.push_back(b[11:4]);
    endtask

    // One conversion from a cleared timer; enable drops as soon as nCS falls.
    task automatic convert_once(input logic [15:0] a, input logic [15:0] b,
                                input bit push, input int mode);
        int f0;
        int start;
        int n;
        w1 = a;
        w2 = b;
        if (push) push_frame(a, b);
        f0     = ncs_falls;
        start  = cyc;
        enable = 1'b1;
        n      = 0;
        while (ncs_falls == f0 && n < 4 * SAMPLE_PERIOD) begin
            step(mode);
            n++;
        end
        check("ncs_fall_seen", 32'(ncs_falls), 32'(f0 + 1));
        check("tick_from_enable", 32'(fall_cyc - start), 32'(SAMPLE_PERIOD));
        enable = 1'b0;
        while (cyc < fall_cyc + LATENCY + 1) step(mode);
    endtask

    task automatic drain(input int mode);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step(mode);
            n++;
        end
        repeat (4) step(mode);
        check("drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int f;
        int n;
        repeat (4) @(posedge clk0);
        #1;
        check("rst_ncs", 32'(adc_ncs), 32'd1);
        check("rst_sclk", 32'(adc_sclk), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_s1", 32'(sample1), 32'd0);
        check("rst_s2", 32'(sample2), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Basic frame, exact latency, enable dropped mid-conversion
        convert_once(16'h0ABC, 16'h0123, 1'b1, 1);
        check("latency", 32'(valid_rise_cyc - fall_cyc), 32'(LATENCY));
        check("s1_abc", 32'(sample1), 32'h0ABC);
        check("s2_123", 32'(sample2), 32'h0123);
        drain(1);
        f = ncs_falls;
        repeat (2 * SAMPLE_PERIOD) step(1);
        check("no_ncs_disabled", 32'(ncs_falls), 32'(f));

        // Full scale then zero, leading bits driven high
        convert_once(16'hFFFF, 16'hFFFF, 1'b1, 1);
        check("s1_fff", 32'(sample1), 32'h0FFF);
        check("s2_fff", 32'(sample2), 32'h0FFF);
        drain(1);
        convert_once(16'hF000, 16'hF000, 1'b1, 1);
        check("s1_000", 32'(sample1), 32'h0000);
        check("s2_000", 32'(sample2), 32'h0000);
        drain(1);

        // Backpressure and overflow
        convert_once(16'h0555, 16'h0AAA, 1'b1, 0);
        check("ovf_first", 32'(overflow), 32'd0);
        check("held_valid", 32'(out_valid), 32'd1);
        check("held_byte0", 32'(out_data), 32'h05);
        convert_once(16'h0111, 16'h0222, 1'b0, 0);
        check("ovf_second", 32'(overflow), 32'd1);
        convert_once(16'h0333, 16'h0444, 1'b0, 0);
        check("held_valid3", 32'(out_valid), 32'd1);
        check("held_byte0_3", 32'(out_data), 32'h05);
        check("s1_dropped", 32'(sample1), 32'h0333);
        check("s2_dropped", 32'(sample2), 32'h0444);
        drain(1);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Ready toggling every cycle
        out_ready = 1'b0;
        convert_once(16'h0321, 16'h0FED, 1'b1, 2);
        drain(2);
        convert_once(16'h0456, 16'h0BCA, 1'b1, 2);
        drain(2);

        // Reset during the 8th SCLK bit
        out_ready = 1'b1;
        w1 = 16'h0777;
        w2 = 16'h0888;
        f = ncs_falls;
        enable = 1'b1;
        n = 0;
        while (ncs_falls == f && n < 4 * SAMPLE_PERIOD) begin
            step(1);
            n++;
        end
        check("abort_fall_seen", 32'(ncs_falls), 32'(f + 1));
        n = 0;
        while (rises_cnt < 7 && n < 100) begin
            step(1);
            n++;
        end
        check("abort_bit7", 32'(rises_cnt), 32'd7);
        reset  = 1'b1;
        enable = 1'b0;
        @(posedge clk0);
        #1;
        check("abort_ncs", 32'(adc_ncs), 32'd1);
        check("abort_sclk", 32'(adc_sclk), 32'd1);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_s1", 32'(sample1), 32'd0);
        check("abort_ovf", 32'(overflow), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (3 * SAMPLE_PERIOD) step(1);
        check("abort_no_ncs", 32'(ncs_falls), 32'(f + 1));
        check("abort_no_frame", 32'(out_valid), 32'd0);
        check("queue_empty_end", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
